// File: rtl/muon_daq_pkg.sv
// Shared constants and types for the muon DAQ readout path.
package muon_daq_pkg;

    // Command bytes understood by the event reader
    localparam logic [7:0] CMD_START  = 8'h73;  // 's'
    localparam logic [7:0] CMD_PART_A = 8'h61;  // 'a'
    localparam logic [7:0] CMD_PART_B = 8'h62;  // 'b'
    localparam logic [7:0] CMD_ACK    = 8'h6B;  // 'k'

    // Byte sent to the host in place of data when the FIFO is empty
    localparam logic [7:0] RESP_EMPTY = 8'h65;  // 'e'

    // Cycles from a command strobe until the reader's half is valid
    localparam int READER_LATENCY_DEFAULT = 2;

    // Readout sequencer states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_SHIFT,
        ST_NEXT,
        ST_ACK,
        ST_DONE
    } seq_state_e;

endpackage

// File: rtl/half_serializer.sv
// Streams a loaded 32-bit half MSB-first as bytes over valid/ready.
// A load may carry 4 bytes (data half) or 1 byte (status byte in [31:24]).
module half_serializer
    import muon_daq_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load_i,
    input  logic [31:0] data_i,
    input  logic        single_i,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic        done_o
);

    logic [31:0] shift_reg;
    logic [2:0]  count_reg;
    logic        valid_reg;
    logic        fire;

    assign fire       = valid_reg & tx_ready_i;
    assign tx_data_o  = shift_reg[31:24];
    assign tx_valid_o = valid_reg;
    assign done_o     = fire & (count_reg == 3'd1);

    // Load, then shift one byte out per accepted transfer; holds while stalled
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_reg <= '0;
            count_reg <= '0;
            valid_reg <= 1'b0;
        end else if (load_i) begin
            shift_reg <= data_i;
            count_reg <= single_i ? 3'd1 : 3'd4;
            valid_reg <= 1'b1;
        end else if (fire) begin
            shift_reg <= {shift_reg[23:0], 8'h00};
            count_reg <= count_reg - 3'd1;
            if (count_reg == 3'd1) begin
                valid_reg <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/event_readout_sequencer.sv
// Autonomous event-dump controller: commands the event reader through
// s, b, (a, b)... and streams every captured half to the UART TX path.
// The reader's aresetn must be driven from ~reset so both restart together.
module event_readout_sequencer
    import muon_daq_pkg::*;
#(
    parameter int CHANNELS       = 16,
    parameter int READER_LATENCY = READER_LATENCY_DEFAULT,
    parameter int HALF_WIDTH     = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic                  empty_i,
    input  logic [HALF_WIDTH-1:0] event_half_i,
    output logic [7:0]            cmd_o,
    output logic [7:0]            tx_data_o,
    output logic                  tx_valid_o,
    input  logic                  tx_ready_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  empty_evt_o
);

    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int WW = (READER_LATENCY > 1) ? $clog2(READER_LATENCY) : 1;
    localparam logic [CW-1:0] LAST_CH   = CW'(CHANNELS - 1);
    localparam logic [WW-1:0] LAST_WAIT = WW'(READER_LATENCY - 1);

    seq_state_e    state_reg, state_next;
    logic [7:0]    cmd_reg, cmd_next;        // command to strobe in ISSUE
    logic          half_b_reg, half_b_next;  // half just requested is B
    logic          empty_reg, empty_next;    // dump is on the empty path
    logic [CW-1:0] chan_reg, chan_next;
    logic [WW-1:0] wait_reg, wait_next;

    logic          ser_load;
    logic [31:0]   ser_data;
    logic          ser_single;
    logic          ser_done;

    half_serializer u_ser (
        .clk        (clk),
        .reset      (reset),
        .load_i     (ser_load),
        .data_i     (ser_data),
        .single_i   (ser_single),
        .tx_data_o  (tx_data_o),
        .tx_valid_o (tx_valid_o),
        .tx_ready_i (tx_ready_i),
        .done_o     (ser_done)
    );

    // Sequencer state and bookkeeping registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= ST_IDLE;
            cmd_reg    <= 8'h00;
            half_b_reg <= 1'b0;
            empty_reg  <= 1'b0;
            chan_reg   <= '0;
            wait_reg   <= '0;
        end else begin
            state_reg  <= state_next;
            cmd_reg    <= cmd_next;
            half_b_reg <= half_b_next;
            empty_reg  <= empty_next;
            chan_reg   <= chan_next;
            wait_reg   <= wait_next;
        end
    end

    // Next-state logic and Moore outputs; cmd_o is nonzero only in ISSUE/ACK
    always_comb begin
        state_next  = state_reg;
        cmd_next    = cmd_reg;
        half_b_next = half_b_reg;
        empty_next  = empty_reg;
        chan_next   = chan_reg;
        wait_next   = wait_reg;
        ser_load    = 1'b0;
        ser_data    = event_half_i;
        ser_single  = 1'b0;
        cmd_o       = 8'h00;
        busy_o      = 1'b1;
        done_o      = 1'b0;
        empty_evt_o = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                busy_o = 1'b0;
                if (start_i) begin
                    state_next  = ST_ISSUE;
                    cmd_next    = CMD_START;
                    half_b_next = 1'b0;
                    empty_next  = 1'b0;
                    chan_next   = '0;
                end
            end
            ST_ISSUE: begin
                cmd_o     = cmd_reg;
                wait_next = '0;
                // The reader makes its empty decision on the same 's' cycle
                if (cmd_reg == CMD_START && empty_i) begin
                    ser_load   = 1'b1;
                    ser_data   = {RESP_EMPTY, 24'h000000};
                    ser_single = 1'b1;
                    empty_next = 1'b1;
                    state_next = ST_SHIFT;
                end else begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (wait_reg == LAST_WAIT) begin
                    ser_load   = 1'b1;
                    state_next = ST_SHIFT;
                end else begin
                    wait_next = wait_reg + 1'b1;
                end
            end
            ST_SHIFT: begin
                if (ser_done) begin
                    state_next = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (empty_reg) begin
                    state_next = ST_ACK;
                end else if (!half_b_reg) begin
                    half_b_next = 1'b1;
                    cmd_next    = CMD_PART_B;
                    state_next  = ST_ISSUE;
                end else if (chan_reg != LAST_CH) begin
                    chan_next   = chan_reg + 1'b1;
                    half_b_next = 1'b0;
                    cmd_next    = CMD_PART_A;
                    state_next  = ST_ISSUE;
                end else begin
                    // Reader returns to standby on its own after the last 'b'
                    state_next = ST_DONE;
                end
            end
            ST_ACK: begin
                cmd_o       = CMD_ACK;
                empty_evt_o = 1'b1;
                state_next  = ST_DONE;
            end
            ST_DONE: begin
                // Guard cycle: the reader reaches standby before a new 's'
                busy_o     = 1'b0;
                done_o     = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                busy_o     = 1'b0;
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_event_readout_sequencer.sv
// Randomized bench for event_readout_sequencer with a transaction-level
// reader model and expected command/byte streams built from dump rules.
module tb_event_readout_sequencer;
    import muon_daq_pkg::*;

    localparam int CH = 16;

    logic        clk = 1'b0;
    logic        reset, start_i, empty_i, tx_ready_i;
    logic [31:0] event_half_i;
    logic [7:0]  cmd_o, tx_data_o;
    logic        tx_valid_o, busy_o, done_o, empty_evt_o;

    always #5 clk = ~clk;

    event_readout_sequencer #(
        .CHANNELS(CH), .READER_LATENCY(2), .HALF_WIDTH(32)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start_i     (start_i),
        .empty_i     (empty_i),
        .event_half_i(event_half_i),
        .cmd_o       (cmd_o),
        .tx_data_o   (tx_data_o),
        .tx_valid_o  (tx_valid_o),
        .tx_ready_i  (tx_ready_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .empty_evt_o (empty_evt_o)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Reference state
    logic [63:0] fifo_q[$];
    logic [7:0]  exp_bytes[$];
    logic [7:0]  exp_cmds[$];
    logic [63:0] rd_word;
    logic [31:0] low_half, pipe0, pipe1;
    bit          pipe0_v, pipe1_v;
    int          cyc = 0;
    int          byte_cnt = 0, done_cnt = 0, evt_cnt = 0;
    int          start_cyc = 0, s_cyc = 0, done_cyc = 0;
    int          done_before = 0, evt_before = 0;
    logic [7:0]  prev_cmd, prev_data;
    bit          prev_stall;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Reader model plus output monitor, sampled on the falling edge
    initial forever begin
        @(negedge clk);
        if (reset) begin
            pipe0_v = 0; pipe1_v = 0; prev_stall = 0; prev_cmd = 8'h00;
            event_half_i = $urandom();
        end else begin
            // Reader: half requested in cycle t is valid from cycle t+2
            if (pipe1_v) event_half_i = pipe1;
            pipe1 = pipe0; pipe1_v = pipe0_v; pipe0_v = 0;
            if ((cmd_o == CMD_START && !empty_i) || cmd_o == CMD_PART_A) begin
                if (fifo_q.size() > 0) begin
                    rd_word  = fifo_q.pop_front();
                    pipe0    = rd_word[63:32];
                    low_half = rd_word[31:0];
                    pipe0_v  = 1;
                end
            end else if (cmd_o == CMD_PART_B) begin
                pipe0 = low_half; pipe0_v = 1;
            end

            if (cmd_o != 8'h00) begin
                check("cmd_width", prev_cmd, 0);
                check("cmd_busy", busy_o, 1);
                if (exp_cmds.size() == 0) check("cmd_extra", cmd_o, 0);
                else check("cmd", cmd_o, exp_cmds.pop_front());
                if (cmd_o == CMD_START) s_cyc = cyc;
            end
            if (prev_stall) check("stall_hold", {tx_valid_o, tx_data_o}, {1'b1, prev_data});
            if (tx_valid_o && !tx_ready_i) check("stall_cmd", cmd_o, 0);
            if (tx_valid_o && tx_ready_i) begin
                byte_cnt++;
                if (exp_bytes.size() == 0) check("byte_extra", {1'b1, tx_data_o}, 0);
                else check("byte", tx_data_o, exp_bytes.pop_front());
            end
            if (done_o) begin
                done_cnt++; done_cyc = cyc;
                check("done_busy", busy_o, 0);
            end
            if (empty_evt_o) begin
                evt_cnt++;
                check("evt_cmd", cmd_o, CMD_ACK);
            end
            prev_stall = tx_valid_o && !tx_ready_i;
            prev_data  = tx_data_o;
            prev_cmd   = cmd_o;
        end
    end

    task automatic start_dump(input bit empty, input bit fixed_first);
        logic [63:0] w;
        fifo_q.delete(); exp_bytes.delete(); exp_cmds.delete();
        byte_cnt = 0; done_before = done_cnt; evt_before = evt_cnt;
        exp_cmds.push_back(CMD_START);
        if (empty) begin
            exp_bytes.push_back(RESP_EMPTY);
            exp_cmds.push_back(CMD_ACK);
        end else begin
            for (int c = 0; c < CH; c++) begin
                w = {$urandom(), $urandom()};
                if (fixed_first && c == 0) w = 64'h0123456789ABCDEF;
                fifo_q.push_back(w);
                for (int b = 7; b >= 0; b--) exp_bytes.push_back(w[b*8 +: 8]);
                if (c > 0) exp_cmds.push_back(CMD_PART_A);
                exp_cmds.push_back(CMD_PART_B);
            end
        end
        empty_i = empty;
        @(posedge clk); #1;
        start_i = 1; start_cyc = cyc;
        @(posedge clk); #1;
        start_i = 0;
    endtask

    // mode 0: ready high; 1: random ready and empty_i noise; 2: ready 1,0,0,1 pattern
    task automatic finish_dump(input bit empty, input int mode, input bit extra_start, input bit timed);
        for (int i = 0; i < 3000 && done_cnt == done_before; i++) begin
            @(posedge clk); #1;
            case (mode)
                0: tx_ready_i = 1;
                1: begin
                    tx_ready_i = 1'($urandom_range(0, 1));
                    if (!empty) empty_i = 1'($urandom_range(0, 1));
                end
                default: tx_ready_i = (i % 4 == 1 || i % 4 == 2) ? 1'b0 : 1'b1;
            endcase
            start_i = extra_start && (i == 20 || i == 21);
        end
        start_i = 0; tx_ready_i = 1; empty_i = empty;
        repeat (6) @(posedge clk);
        #1;
        check("done_pulses", done_cnt, done_before + 1);
        check("empty_evts", evt_cnt, evt_before + (empty ? 1 : 0));
        check("bytes_left", exp_bytes.size(), 0);
        check("cmds_left", exp_cmds.size(), 0);
        check("busy_idle", busy_o, 0);
        if (timed) begin
            check("issue_latency", s_cyc - start_cyc, 1);
            check("dump_cycles", done_cyc - s_cyc, empty ? 4 : 16 * CH);
        end
        $display("dump empty=%0d mode=%0d extra_start=%0d bytes=%0d checks=%0d errors=%0d",
                 empty, mode, extra_start, byte_cnt, n_checks, n_errors);
    endtask

    initial begin
        reset = 1; start_i = 0; empty_i = 0; tx_ready_i = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_state", {cmd_o, tx_data_o, tx_valid_o, busy_o, done_o, empty_evt_o}, 0);
        @(posedge clk); #1;
        reset = 0; tx_ready_i = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("idle_ready", {cmd_o, tx_valid_o, busy_o}, 0);

        start_dump(0, 1); finish_dump(0, 0, 0, 1);
        start_dump(0, 0); finish_dump(0, 1, 0, 0);
        start_dump(1, 0); finish_dump(1, 0, 0, 1);
        start_dump(0, 0); finish_dump(0, 2, 0, 0);
        start_dump(0, 0); finish_dump(0, 0, 1, 1);

        // Reset while channel 5 is on its third byte, then a fresh dump
        start_dump(0, 0);
        tx_ready_i = 1;
        for (int i = 0; i < 2000 && byte_cnt < 42; i++) begin
            @(posedge clk); #1;
        end
        check("pre_reset_bytes", byte_cnt, 42);
        reset = 1;
        @(posedge clk);
        repeat (2) begin
            @(negedge clk);
            check("rst_outputs", {cmd_o, tx_data_o, tx_valid_o, busy_o, done_o, empty_evt_o}, 0);
        end
        fifo_q.delete(); exp_bytes.delete(); exp_cmds.delete();
        @(posedge clk); #1;
        reset = 0;
        $display("reset mid-dump applied after %0d bytes", byte_cnt);
        start_dump(0, 0); finish_dump(0, 0, 0, 1);

        start_dump(1, 0); finish_dump(1, 1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
